// File: rtl/crc7_pkg.sv
// Shared definitions for the serial SD-card CRC7 generator.
//   CRC7_POLY   : generator taps for x^7 + x^3 + 1 (x^7 implicit)
//   CRC7_DATA_W : SD command frame length in bits
//   crc7_state_e: controller states
//   crc7_next() : one-bit MSB-first CRC7 update
package crc7_pkg;

  localparam logic [6:0]  CRC7_POLY   = 7'h09;
  localparam int unsigned CRC7_DATA_W = 40;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } crc7_state_e;

  // Feedback is the incoming message bit XOR the CRC MSB; on feedback the taps are folded in.
  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din,
                                           input logic [6:0] poly);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? poly : 7'h00);
  endfunction

endpackage

// File: rtl/crc7_step.sv
// Combinational single-bit CRC7 update.
//   crc_in  : current CRC register value
//   bit_in  : next message bit (MSB-first)
//   crc_out : CRC after absorbing bit_in
module crc7_step
  import crc7_pkg::*;
#(
  parameter logic [6:0] Poly = CRC7_POLY
) (
  input  logic [6:0] crc_in,
  input  logic       bit_in,
  output logic [6:0] crc_out
);

  always_comb begin
    crc_out = crc7_next(crc_in, bit_in, Poly);
  end

endmodule

// File: rtl/crc_7.sv
// Serial CRC7 generator for SD-card command frames, one message bit per clock.
//   CLK    : system clock, rising edge
//   RST    : synchronous active-high reset, overrides Enable
//   Enable : level request; rising in idle loads data_i and starts, low aborts / returns to idle
//   data_i : message, MSB first, sampled only on the load edge
//   CRC    : CRC7 result, valid while done is high
//   done   : registered completion flag
module crc_7
  import crc7_pkg::*;
#(
  parameter int unsigned DATA_W = CRC7_DATA_W,
  parameter logic [6:0]  POLY   = CRC7_POLY
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Enable,
  input  logic [DATA_W-1:0] data_i,
  output logic [6:0]        CRC,
  output logic              done
);

  localparam int unsigned     CntW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  crc7_state_e       state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [6:0]        crc_q, crc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [6:0]        crc_step;

  crc7_step #(
    .Poly (POLY)
  ) u_step (
    .crc_in  (crc_q),
    .bit_in  (shreg_q[DATA_W-1]),
    .crc_out (crc_step)
  );

  // State register and datapath flops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      shreg_q <= '0;
      crc_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (Enable) state_d = StShift;
      StShift: begin
        if (!Enable) begin
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          state_d = StDone;
        end
      end
      StDone:  if (!Enable) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    shreg_d = shreg_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    // done rises one edge after entering StDone and falls on the edge Enable is seen low.
    done_d  = (state_q == StDone) && Enable;
    unique case (state_q)
      StIdle: begin
        if (Enable) begin
          shreg_d = data_i;
          crc_d   = '0;
          cnt_d   = '0;
        end
      end
      StShift: begin
        // An abort leaves the partial CRC in place; it is not flagged valid.
        if (Enable) begin
          crc_d   = crc_step;
          shreg_d = shreg_q << 1;
          cnt_d   = (cnt_q == CntLast) ? cnt_q : cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign CRC  = crc_q;
  assign done = done_q;

endmodule

// File: tb/tb_crc_7.sv
// Directed self-checking bench for crc_7 using known SD command CRC7 values.
module tb_crc_7;

  localparam logic [39:0] Cmd0  = 40'h4000000000;
  localparam logic [39:0] Cmd17 = 40'h5100000000;
  localparam logic [39:0] Cmd8  = 40'h48000001AA;
  localparam logic [39:0] Cmd55 = 40'h7700000000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Enable;
  logic [39:0] data_i;
  logic [6:0]  CRC;
  logic        done;

  int checks = 0;
  int errors = 0;

  crc_7 dut (
    .CLK    (CLK),
    .RST    (RST),
    .Enable (Enable),
    .data_i (data_i),
    .CRC    (CRC),
    .done   (done)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns to idle, loads msg, and counts edges (load edge = 0) until done is seen.
  // If change_at >= 0, data_i is overwritten with alt after that edge.
  task automatic run_crc(input string tag, input logic [39:0] msg, input logic [6:0] exp_crc,
                         input int change_at, input logic [39:0] alt);
    int lat;
    Enable = 1'b0;
    tick();
    data_i = msg;
    Enable = 1'b1;
    lat = -1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (i == change_at) data_i = alt;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'd41);
    chk({tag, "_crc"}, {57'd0, CRC}, {57'd0, exp_crc});
  endtask

  initial begin
    bit saw_done;

    // 1. Reset, with Enable held high throughout.
    RST    = 1'b1;
    Enable = 1'b1;
    data_i = Cmd0;
    tick();
    tick();
    chk("rst_crc", {57'd0, CRC}, 64'h0);
    chk("rst_done", {63'd0, done}, 64'h0);
    saw_done = 1'b0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("rst_hold_idle", {63'd0, saw_done}, 64'h0);
    RST = 1'b0;

    // 2. CMD0, then hold Enable.
    run_crc("cmd0", Cmd0, 7'h4A, -1, '0);
    for (int i = 0; i < 5; i++) tick();
    chk("cmd0_hold_done", {63'd0, done}, 64'h1);
    chk("cmd0_hold_crc", {57'd0, CRC}, 64'h4A);

    // 3. Drop Enable, done falls on the next edge; then CMD17.
    Enable = 1'b0;
    data_i = Cmd17;
    tick();
    chk("done_drop", {63'd0, done}, 64'h0);
    tick();
    run_crc("cmd17", Cmd17, 7'h2A, -1, '0);

    // 4. CMD8 and CMD55.
    run_crc("cmd8", Cmd8, 7'h43, -1, '0);
    run_crc("cmd55", Cmd55, 7'h32, -1, '0);

    // 5. Abort at SHIFT edge 20, done must never rise.
    Enable = 1'b0;
    tick();
    data_i   = Cmd8;
    Enable   = 1'b1;
    saw_done = 1'b0;
    tick();
    for (int i = 1; i < 20; i++) begin
      tick();
      if (done === 1'b1) saw_done = 1'b1;
    end
    Enable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("abort_no_done", {63'd0, saw_done}, 64'h0);
    run_crc("abort_rerun", Cmd8, 7'h43, -1, '0);

    // 6a. data_i changed mid-SHIFT is ignored.
    run_crc("data_change", Cmd55, 7'h32, 10, Cmd0);

    // 6b. Reset mid-SHIFT.
    Enable = 1'b0;
    tick();
    data_i = Cmd17;
    Enable = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    RST = 1'b1;
    tick();
    chk("rst_mid_crc", {57'd0, CRC}, 64'h0);
    chk("rst_mid_done", {63'd0, done}, 64'h0);
    Enable = 1'b0;
    tick();
    RST = 1'b0;
    run_crc("post_rst", Cmd17, 7'h2A, -1, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
